mem_access: RTL and testbench

Memory-stage access controller for the 16-bit pipeline. It consumes the MEM-stage control and data that `ex_mem` presents (`memread`, `memwrite`, `memdata`, `alures`) and runs the multi-cycle handshake with the external asynchronous SRAM. While an access is in flight it holds the pipeline with `stall_o`. It delivers a write-back-ready result to `mem_wb`.

---
 rtl/mem_access_if.sv | 50 +++++
 rtl/mem_access.sv | 138 +++++++++++++
 tb/tb_mem_access.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bus bundle between the MEM pipeline stage, the access controller and the
// external asynchronous SRAM.
//   pipeline side : regwrite/memtoreg/memread/memwrite/memdata/regdst/alures in,
//                   regwrite/memtoreg/regdst/wbdata/stall out
//   sram side     : ram_addr/ram_data/ram_data_oe/strobes out, ram_data_i in
// slave  = the controller, master = everything around it.
interface mem_access_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned REG_W  = 4;

  // from ex_mem
  logic              regwrite_i;
  logic              memtoreg_i;
  logic              memread_i;
  logic              memwrite_i;
  logic [DATA_W-1:0] memdata_i;
  logic [REG_W-1:0]  regdst_i;
  logic [DATA_W-1:0] alures_i;

  // to mem_wb and pipeline control
  logic              regwrite_o;
  logic              memtoreg_o;
  logic [REG_W-1:0]  regdst_o;
  logic [DATA_W-1:0] wbdata_o;
  logic              stall_o;

  // SRAM pins
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic              ram_data_oe;
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_en_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  regwrite_i, memtoreg_i, memread_i, memwrite_i, memdata_i,
           regdst_i, alures_i, ram_data_i,
    output regwrite_o, memtoreg_o, regdst_o, wbdata_o, stall_o,
           ram_addr_o, ram_data_o, ram_data_oe, ram_en_n, ram_oe_n, ram_we_n
  );

  modport master (
    output regwrite_i, memtoreg_i, memread_i, memwrite_i, memdata_i,
           regdst_i, alures_i, ram_data_i,
    input  regwrite_o, memtoreg_o, regdst_o, wbdata_o, stall_o,
           ram_addr_o, ram_data_o, ram_data_oe, ram_en_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access controller: runs the multi-cycle handshake with an
// external asynchronous SRAM for loads/stores and stalls the pipeline while
// an access is in flight.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - mem_access_if.slave (pipeline request/result + SRAM pins)
// Parameters:
//   RD_WAIT  - cycles the read strobes are held before data is sampled (1..7)
//   WR_WIDTH - cycles ram_we_n is held low (1..7)
module mem_access #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_WIDTH = 1
) (
  input  logic        CLK,
  input  logic        RST,
  mem_access_if.slave bus
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              data_oe_q;
  logic              stall;

  // Access sequencer; SRAM strobes are set on the edge that enters each
  // state so they line up with the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      en_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Read wins if both requests are present; the write is dropped.
          if (bus.memread_i) begin
            state  <= RD_ACC;
            cnt    <= CNT_W'(RD_WAIT - 1);
            addr_q <= ADDR_W'(bus.alures_i);
            en_n_q <= 1'b0;
            oe_n_q <= 1'b0;
          end else if (bus.memwrite_i) begin
            state     <= WR_SETUP;
            addr_q    <= ADDR_W'(bus.alures_i);
            wdata_q   <= bus.memdata_i;
            en_n_q    <= 1'b0;
            data_oe_q <= 1'b1;
          end
        end

        RD_ACC: begin
          if (cnt == '0) begin
            rdata_q <= bus.ram_data_i;
            state   <= DONE;
            en_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WR_SETUP: begin
          // Address/data have been stable for this whole cycle before we_n falls.
          cnt    <= CNT_W'(WR_WIDTH - 1);
          we_n_q <= 1'b0;
          state  <= WR_PULSE;
        end

        WR_PULSE: begin
          if (cnt == '0) begin
            we_n_q <= 1'b1;
            state  <= WR_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WR_HOLD: begin
          en_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          state     <= DONE;
        end

        DONE: begin
          // Never launches an access, so a request held across DONE cannot re-issue.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the request cycle in IDLE plus every busy state.
  assign stall = ((state == IDLE) && (bus.memread_i || bus.memwrite_i)) ||
                 ((state != IDLE) && (state != DONE));

  assign bus.stall_o     = stall;
  assign bus.regwrite_o  = bus.regwrite_i & ~stall;
  assign bus.memtoreg_o  = bus.memtoreg_i;
  assign bus.regdst_o    = bus.regdst_i;
  assign bus.wbdata_o    = bus.memtoreg_i ? rdata_q : bus.alures_i;

  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_data_o  = wdata_q;
  assign bus.ram_data_oe = data_oe_q;
  assign bus.ram_en_n    = en_n_q;
  assign bus.ram_oe_n    = oe_n_q;
  assign bus.ram_we_n    = we_n_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: one DUT with default timing backed by a
// word-addressed SRAM model, and one with RD_WAIT=3 whose SRAM returns ~addr.
module tb_mem_access;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  mem_access_if a ();
  mem_access_if b ();

  mem_access #(.RD_WAIT(1), .WR_WIDTH(1)) dut_a (.CLK(CLK), .RST(RST), .bus(a.slave));
  mem_access #(.RD_WAIT(3), .WR_WIDTH(1)) dut_b (.CLK(CLK), .RST(RST), .bus(b.slave));

  always #5 CLK = ~CLK;

  // SRAM model for dut_a: async read while selected, write on rising we_n.
  logic [15:0] mem [0:65535];
  assign a.ram_data_i = (!a.ram_en_n && !a.ram_oe_n) ? mem[a.ram_addr_o[15:0]] : 16'h0000;
  always @(posedge a.ram_we_n) begin
    if (a.ram_en_n === 1'b0 && a.ram_data_oe === 1'b1)
      mem[a.ram_addr_o[15:0]] = a.ram_data_o;
  end

  // SRAM for dut_b returns the inverted address.
  assign b.ram_data_i = (!b.ram_en_n && !b.ram_oe_n) ? ~b.ram_addr_o[15:0] : 16'h0000;

  task automatic drive_idle();
    a.regwrite_i = 1'b0; a.memtoreg_i = 1'b0; a.memread_i = 1'b0; a.memwrite_i = 1'b0;
    a.memdata_i  = 16'h0000; a.regdst_i = 4'h0; a.alures_i = 16'h0000;
    b.regwrite_i = 1'b0; b.memtoreg_i = 1'b0; b.memread_i = 1'b0; b.memwrite_i = 1'b0;
    b.memdata_i  = 16'h0000; b.regdst_i = 4'h0; b.alures_i = 16'h0000;
  endtask

  // Steps dut_a cycle by cycle (sampling at negedge+1) until stall drops;
  // returns observations of the stalled cycles. Ends inside the DONE cycle.
  task automatic run_a(input logic [15:0] exp_data, output int n_stall, output int n_we,
                       output int n_oe, output bit overlap, output bit data_bad,
                       output bit rw_bad, output bit timeout);
    n_stall = 0; n_we = 0; n_oe = 0;
    overlap = 1'b0; data_bad = 1'b0; rw_bad = 1'b0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (a.stall_o !== 1'b1) begin
        timeout = 1'b0;
        break;
      end
      n_stall++;
      if (a.ram_we_n === 1'b0) n_we++;
      if (a.ram_data_oe === 1'b1) begin
        n_oe++;
        if (a.ram_data_o !== exp_data) data_bad = 1'b1;
      end
      if (a.ram_oe_n === 1'b0 && a.ram_we_n === 1'b0) overlap = 1'b1;
      if (a.regwrite_o !== 1'b0) rw_bad = 1'b1;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    drive_idle();
    a.alures_i = 16'h1234;
    a.regwrite_i = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if ({a.ram_en_n, a.ram_oe_n, a.ram_we_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b expected 111", {a.ram_en_n, a.ram_oe_n, a.ram_we_n}); end
    checks++; if (a.ram_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", a.ram_data_oe); end
    checks++; if (a.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a.stall_o); end
    checks++; if (a.wbdata_o !== 16'h1234) begin errors++; $display("FAIL reset_wbdata_alu: got %h expected 1234", a.wbdata_o); end
    checks++; if (a.ram_addr_o !== 18'h00000 || a.ram_data_o !== 16'h0000) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", a.ram_addr_o, a.ram_data_o); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    a.memtoreg_i = 1'b1;
    #1;
    checks++; if (a.wbdata_o !== 16'h0000) begin errors++; $display("FAIL reset_rdata_q: got %h expected 0000", a.wbdata_o); end
    checks++; if (a.regwrite_o !== 1'b1 || a.stall_o !== 1'b0) begin errors++; $display("FAIL idle_regwrite_pass: got rw=%b stall=%b expected 1/0", a.regwrite_o, a.stall_o); end
    a.memtoreg_i = 1'b0;
    a.regwrite_i = 1'b0;
  endtask

  task automatic test_read();
    int n_stall, n_we, n_oe; bit ov, db, rwb, to;
    @(negedge CLK);
    a.memread_i = 1'b1; a.memtoreg_i = 1'b1; a.regwrite_i = 1'b1;
    a.alures_i = 16'h0123; a.regdst_i = 4'h5;
    run_a(16'h0000, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to) begin errors++; $display("FAIL read_timeout: stall never dropped"); end
    checks++; if (n_stall != 2) begin errors++; $display("FAIL read_stall_cycles: got %0d expected 2", n_stall); end
    checks++; if (rwb) begin errors++; $display("FAIL read_regwrite_in_stall: got 1 expected 0"); end
    checks++; if (a.ram_addr_o !== 18'h00123) begin errors++; $display("FAIL read_addr: got %h expected 00123", a.ram_addr_o); end
    checks++; if (a.wbdata_o !== 16'habcd) begin errors++; $display("FAIL read_wbdata: got %h expected abcd", a.wbdata_o); end
    checks++; if (a.regwrite_o !== 1'b1 || a.regdst_o !== 4'h5 || a.memtoreg_o !== 1'b1) begin errors++; $display("FAIL read_done_wb: got rw=%b rd=%h mtr=%b expected 1/5/1", a.regwrite_o, a.regdst_o, a.memtoreg_o); end
    checks++; if ({a.ram_en_n, a.ram_oe_n, a.ram_we_n, a.ram_data_oe} !== 4'b1110) begin errors++; $display("FAIL read_done_strobes: got %b expected 1110", {a.ram_en_n, a.ram_oe_n, a.ram_we_n, a.ram_data_oe}); end
    checks++; if (n_we != 0) begin errors++; $display("FAIL read_we_low: got %0d expected 0", n_we); end
    drive_idle();
    @(negedge CLK);
    #1;
    checks++; if (a.stall_o !== 1'b0 || a.wbdata_o !== 16'h0000) begin errors++; $display("FAIL read_no_reissue: got stall=%b wb=%h expected 0/0000", a.stall_o, a.wbdata_o); end
  endtask

  task automatic test_write();
    int n_stall, n_we, n_oe; bit ov, db, rwb, to;
    @(negedge CLK);
    a.memwrite_i = 1'b1; a.memdata_i = 16'habcd; a.alures_i = 16'hdcba; a.regdst_i = 4'b0011;
    run_a(16'habcd, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to) begin errors++; $display("FAIL write_timeout: stall never dropped"); end
    checks++; if (n_stall != 4) begin errors++; $display("FAIL write_stall_cycles: got %0d expected 4", n_stall); end
    checks++; if (n_we != 1) begin errors++; $display("FAIL write_we_width: got %0d expected 1", n_we); end
    checks++; if (n_oe != 3 || db) begin errors++; $display("FAIL write_setup_hold: got oe_cycles=%0d data_bad=%b expected 3/0", n_oe, db); end
    checks++; if (ov) begin errors++; $display("FAIL write_oe_we_overlap: got 1 expected 0"); end
    checks++; if (a.wbdata_o !== 16'hdcba || a.regdst_o !== 4'b0011) begin errors++; $display("FAIL write_done_passthru: got wb=%h rd=%h expected dcba/3", a.wbdata_o, a.regdst_o); end
    drive_idle();
    @(negedge CLK);
    checks++; if (mem[16'hdcba] !== 16'habcd) begin errors++; $display("FAIL write_sram_content: got %h expected abcd", mem[16'hdcba]); end
  endtask

  task automatic test_back_to_back();
    int n_stall, n_we, n_oe; bit ov, db, rwb, to;
    @(negedge CLK);
    a.memwrite_i = 1'b1; a.memdata_i = 16'h5555; a.alures_i = 16'h0010;
    run_a(16'h5555, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to || n_stall != 4 || ov) begin errors++; $display("FAIL b2b_store: got stall=%0d overlap=%b timeout=%b expected 4/0/0", n_stall, ov, to); end
    // Next instruction arrives as DONE's edge advances the pipeline.
    a.memwrite_i = 1'b0; a.memread_i = 1'b1; a.memtoreg_i = 1'b1; a.regwrite_i = 1'b1;
    @(negedge CLK);
    run_a(16'h0000, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to || n_stall != 2) begin errors++; $display("FAIL b2b_load_stall: got %0d timeout=%b expected 2/0", n_stall, to); end
    checks++; if (ov || n_we != 0) begin errors++; $display("FAIL b2b_load_strobes: got overlap=%b we_cycles=%0d expected 0/0", ov, n_we); end
    checks++; if (a.wbdata_o !== 16'h5555) begin errors++; $display("FAIL b2b_load_data: got %h expected 5555", a.wbdata_o); end
    drive_idle();
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_access();
    int n_stall, n_we, n_oe; bit ov, db, rwb, to; bit found;
    @(negedge CLK);
    a.memwrite_i = 1'b1; a.memdata_i = 16'hbeef; a.alures_i = 16'h0040;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (a.ram_we_n === 1'b0) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_pulse: we_n never went low"); end
    RST = 1'b0;
    #1;
    checks++; if (a.ram_we_n !== 1'b1 || a.ram_data_oe !== 1'b0 || a.ram_en_n !== 1'b1) begin errors++; $display("FAIL midrst_strobes: got we_n=%b oe=%b en_n=%b expected 1/0/1", a.ram_we_n, a.ram_data_oe, a.ram_en_n); end
    checks++; if (a.stall_o !== 1'b1 || a.ram_addr_o !== 18'h00000) begin errors++; $display("FAIL midrst_stall_req: got stall=%b addr=%h expected 1/00000", a.stall_o, a.ram_addr_o); end
    a.memwrite_i = 1'b0;
    #1;
    checks++; if (a.stall_o !== 1'b0) begin errors++; $display("FAIL midrst_stall_noreq: got %b expected 0", a.stall_o); end
    a.memwrite_i = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    checks++; if (a.ram_we_n !== 1'b1 || a.ram_data_oe !== 1'b1 || a.ram_en_n !== 1'b0 || a.ram_data_o !== 16'hbeef) begin errors++; $display("FAIL midrst_restart_setup: got we_n=%b oe=%b en_n=%b d=%h expected 1/1/0/beef", a.ram_we_n, a.ram_data_oe, a.ram_en_n, a.ram_data_o); end
    run_a(16'hbeef, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to || n_stall != 3 || n_we != 1) begin errors++; $display("FAIL midrst_finish: got stall=%0d we=%0d timeout=%b expected 3/1/0", n_stall, n_we, to); end
    drive_idle();
    @(negedge CLK);
    checks++; if (mem[16'h0040] !== 16'hbeef) begin errors++; $display("FAIL midrst_sram_content: got %h expected beef", mem[16'h0040]); end
  endtask

  task automatic test_conflict_params();
    int n_stall, n_we, n_oe; bit ov, db, rwb, to; int nb; bit we_seen, done;
    @(negedge CLK);
    a.memread_i = 1'b1; a.memwrite_i = 1'b1; a.memtoreg_i = 1'b1;
    a.memdata_i = 16'h9999; a.alures_i = 16'h0123;
    run_a(16'h9999, n_stall, n_we, n_oe, ov, db, rwb, to);
    checks++; if (to || n_stall != 2) begin errors++; $display("FAIL conflict_stall: got %0d timeout=%b expected 2/0", n_stall, to); end
    checks++; if (n_we != 0 || n_oe != 0) begin errors++; $display("FAIL conflict_no_write: got we=%0d oe=%0d expected 0/0", n_we, n_oe); end
    checks++; if (a.wbdata_o !== 16'habcd) begin errors++; $display("FAIL conflict_read_data: got %h expected abcd", a.wbdata_o); end
    drive_idle();
    @(negedge CLK);
    checks++; if (mem[16'h0123] !== 16'habcd) begin errors++; $display("FAIL conflict_sram_intact: got %h expected abcd", mem[16'h0123]); end

    b.memread_i = 1'b1; b.memwrite_i = 1'b1; b.memtoreg_i = 1'b1;
    b.memdata_i = 16'h1111; b.alures_i = 16'h0077;
    nb = 0; we_seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (b.stall_o !== 1'b1) begin done = 1'b1; break; end
      nb++;
      if (b.ram_we_n !== 1'b1) we_seen = 1'b1;
      @(negedge CLK);
    end
    checks++; if (!done || nb != 4) begin errors++; $display("FAIL rdwait3_stall: got %0d done=%b expected 4/1", nb, done); end
    checks++; if (we_seen) begin errors++; $display("FAIL rdwait3_no_write: got we low expected none"); end
    checks++; if (b.wbdata_o !== 16'hff88) begin errors++; $display("FAIL rdwait3_data: got %h expected ff88", b.wbdata_o); end
    drive_idle();
    @(negedge CLK);
  endtask

  initial begin
    mem[16'h0123] = 16'habcd;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_access();
    test_conflict_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
